binary_divider: RTL and testbench

//   Sequential unsigned restoring divider: quotient = floor(g_dividend_Q / g_divider_Q),
//   8-bit result saturated at 255. Sits in the gradient datapath; converts two 16-bit

---
 rtl/binary_divider_if.sv | 10 +
 rtl/binary_divider.sv | 72 +++++++
 tb/tb_binary_divider.sv | 120 ++++++++++++
 3 files changed

// File: rtl/binary_divider_if.sv
// binary_divider_if: enable/ready handshake plus operands (master drives) and quotient (slave drives)
interface binary_divider_if #(parameter int DW = 16, parameter int QW = 8);
  logic          enable;
  logic [DW-1:0] g_dividend_Q;
  logic [DW-1:0] g_divider_Q;
  logic [QW-1:0] quotient;
  logic          ready;
  modport master(output enable, g_dividend_Q, g_divider_Q, input quotient, ready);
  modport slave(input enable, g_dividend_Q, g_divider_Q, output quotient, ready);
endinterface

// File: rtl/binary_divider.sv
// binary_divider: sequential restoring divider, one quotient bit per clock, saturates at all-ones
// Ports: clk; reset (sync, active-low); bus.slave carries enable, g_dividend_Q, g_divider_Q in
// and quotient, ready out.
module binary_divider #(
  parameter int DW = 16,
  parameter int QW = 8
) (
  input logic            clk,
  input logic            reset,
  binary_divider_if.slave bus
);
  localparam int CW = QW > 1 ? $clog2(QW) : 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t        state;
  logic [DW-1:0] rem;
  logic [DW-1:0] dvs;
  logic [CW-1:0] cnt;
  logic [QW-1:0] qb;
  logic          sat;
  logic [DW+QW-1:0] sh;
  logic          ge;
  always_comb begin
    sh = {{QW{1'b0}}, dvs} << cnt;
    ge = {{QW{1'b0}}, rem} >= sh;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      rem          <= '0;
      dvs          <= '0;
      cnt          <= '0;
      qb           <= '0;
      sat          <= 1'b0;
      bus.quotient <= '0;
      bus.ready    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.ready <= 1'b0;
          if (bus.enable) begin
            rem   <= bus.g_dividend_Q;
            dvs   <= bus.g_divider_Q;
            cnt   <= CW'(QW - 1);
            qb    <= '0;
            // quotient cannot fit in QW bits, or divide by zero
            sat   <= (bus.g_divider_Q == '0) ||
                     ({{QW{1'b0}}, bus.g_dividend_Q} >= {bus.g_divider_Q, {QW{1'b0}}});
            state <= CALC;
          end
        end
        CALC: begin
          if (ge) rem <= rem - sh[DW-1:0];
          qb[cnt] <= ge;
          if (cnt == '0) begin
            bus.quotient <= sat ? '1 : (qb | {{(QW-1){1'b0}}, ge});
            bus.ready    <= 1'b1;
            state        <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (!bus.enable) begin
            bus.ready <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_binary_divider.sv
// tb_binary_divider: directed vectors against a transaction-level model of the divider
module tb_binary_divider;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  binary_divider_if #(.DW(16), .QW(8)) bus ();
  binary_divider #(.DW(16), .QW(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int ref_div(input int a, input int b);
    if (b == 0) return 255;
    return (a / b > 255) ? 255 : a / b;
  endfunction

  // Model: a request taken at an edge produces its result 8 edges later; the result is
  // then shown until an edge sees enable low.
  int   pending = 0;
  int   result = 0;
  logic exp_ready = 1'b0;
  int   exp_q = 0;
  logic model_on = 1'b0;
  always @(posedge clk) begin
    if (!reset) begin
      pending   = 0;
      exp_ready = 1'b0;
      exp_q     = 0;
      model_on  = 1'b1;
    end else if (pending > 0) begin
      pending--;
      if (pending == 0) begin
        exp_ready = 1'b1;
        exp_q     = result;
      end
    end else if (exp_ready) begin
      if (!bus.enable) exp_ready = 1'b0;
    end else if (bus.enable) begin
      pending = 8;
      result  = ref_div(int'(bus.g_dividend_Q), int'(bus.g_divider_Q));
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("ready", 32'(bus.ready), 32'(exp_ready));
      chk("quotient", 32'(bus.quotient), 32'(exp_q));
    end
  end

  // Called at a negedge right before the start edge; counts edges until ready.
  task automatic wait_ready(input string name, input int exp, input bit change);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
      if (change && n == 2) begin
        bus.g_dividend_Q = 16'd1000;
        bus.g_divider_Q  = 16'd10;
      end
    end while (!bus.ready && n < 30);
    chk({name, "_latency"}, 32'(n - 1), 32'd8);
    chk({name, "_lit"}, 32'(bus.quotient), 32'(exp));
    repeat (4) @(negedge clk);
    chk({name, "_hold"}, 32'(bus.ready), 32'd1);
    bus.enable = 1'b0;
    @(negedge clk);
    chk({name, "_drop"}, 32'(bus.ready), 32'd0);
  endtask

  task automatic run(input string name, input int a, input int b, input int exp, input bit change);
    bus.g_dividend_Q = 16'(a);
    bus.g_divider_Q  = 16'(b);
    bus.enable       = 1'b1;
    wait_ready(name, exp, change);
  endtask

  initial begin
    reset            = 1'b0;
    bus.enable       = 1'b0;
    bus.g_dividend_Q = '0;
    bus.g_divider_Q  = '0;
    repeat (2) @(negedge clk);
    chk("reset_ready", 32'(bus.ready), 32'd0);
    chk("reset_q", 32'(bus.quotient), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    run("765_63", 765, 63, 12, 1'b0);
    run("16065_63", 16065, 63, 255, 1'b0);
    run("16128_63", 16128, 63, 255, 1'b0);
    run("65535_1", 65535, 1, 255, 1'b0);
    run("100_0", 100, 0, 255, 1'b0);
    run("0_5", 0, 5, 0, 1'b0);
    run("62_63", 62, 63, 0, 1'b0);
    run("63_63", 63, 63, 1, 1'b0);
    run("change", 765, 63, 12, 1'b1);
    run("b2b_a", 765, 63, 12, 1'b0);
    run("b2b_b", 500, 7, 71, 1'b0);
    bus.g_dividend_Q = 16'd765;
    bus.g_divider_Q  = 16'd63;
    bus.enable       = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midreset_ready", 32'(bus.ready), 32'd0);
    chk("midreset_q", 32'(bus.quotient), 32'd0);
    reset = 1'b1;
    wait_ready("after_reset", 12, 1'b0);
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
